// File: rtl/adder_tree_pkg.sv
// Shared constants, state encoding and data types for the adder-tree feeder.
package adder_tree_pkg;

    localparam int ADDER_WIDTH = 6;
    localparam int LEVELS      = 3;
    localparam int N           = 1 << LEVELS;
    localparam int SUM_WIDTH   = ADDER_WIDTH + LEVELS;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2
    } state_e;

    typedef logic [ADDER_WIDTH-1:0] operand_t;
    typedef logic [SUM_WIDTH-1:0]   sum_t;

endpackage

// File: rtl/adder_tree_sum_check.sv
// Local serial running sum of a frame, compared against the tree result.
// Keeps a sticky mismatch flag and a saturating count of bad frames.
module adder_tree_sum_check #(
    parameter int ADDER_WIDTH   = 6,
    parameter int LEVELS        = 3,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_i,
    input  logic                           add_en_i,
    input  logic [ADDER_WIDTH-1:0]         add_data_i,
    input  logic                           check_i,
    input  logic [ADDER_WIDTH+LEVELS-1:0]  tree_sum_i,
    output logic [ADDER_WIDTH+LEVELS-1:0]  acc_o,
    output logic                           mismatch_o,
    output logic [ERR_CNT_WIDTH-1:0]       err_count_o
);

    localparam int SUM_W = ADDER_WIDTH + LEVELS;

    logic [SUM_W-1:0]         acc_q, acc_d;
    logic                     mismatch_q, mismatch_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + ERR_CNT_WIDTH'(1);
        end
    endfunction

    // Next-state for the accumulator and the error bookkeeping.
    always_comb begin
        acc_d       = acc_q;
        mismatch_d  = mismatch_q;
        err_count_d = err_count_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (add_en_i) begin
            acc_d = acc_q + SUM_W'(add_data_i);
        end else begin
            acc_d = acc_q;
        end
        if (check_i && (tree_sum_i != acc_q)) begin
            mismatch_d  = 1'b1;
            err_count_d = sat_inc(err_count_q);
        end else begin
            mismatch_d  = mismatch_q;
            err_count_d = err_count_q;
        end
    end

    // Accumulator and error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
        end
    end

    assign acc_o       = acc_q;
    assign mismatch_o  = mismatch_q;
    assign err_count_o = err_count_q;

endmodule

// File: rtl/adder_tree_feeder.sv
// Collects a frame of 2**LEVELS operands from a stream, drives them in
// parallel to the adder tree, waits out its latency and returns the sum on
// a valid/ready port while cross-checking it against a serial running sum.
module adder_tree_feeder
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH   = 6,
    parameter int LEVELS        = 3,
    parameter int TREE_LATENCY  = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [ADDER_WIDTH-1:0]                s_data,
    output logic [(2**LEVELS)*ADDER_WIDTH-1:0]    op_bus,
    input  logic [ADDER_WIDTH+LEVELS-1:0]         tree_sum,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [ADDER_WIDTH+LEVELS-1:0]         m_data,
    output logic                                  mismatch,
    output logic [ERR_CNT_WIDTH-1:0]              err_count,
    output logic                                  frame_done
);

    localparam int N_OPS = 2 ** LEVELS;
    localparam int SUM_W = ADDER_WIDTH + LEVELS;
    localparam int CNT_W = $clog2(TREE_LATENCY + 2);
    localparam int BUS_W = N_OPS * ADDER_WIDTH;

    state_e               state_q, state_d;
    logic [LEVELS-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_W-1:0]     op_bus_q, op_bus_d;
    logic [SUM_W-1:0]     m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic                 s_ready_s;
    logic                 accept_s;
    logic                 last_s;
    logic                 cnt_done_s;
    logic                 handshake_s;
    logic                 add_en_s;
    logic                 check_s;
    logic                 clear_s;
    logic [SUM_W-1:0]     acc_s;

    assign accept_s    = s_valid && s_ready_s;
    assign last_s      = accept_s && (idx_q == LEVELS'(N_OPS - 1));
    assign cnt_done_s  = (state_q == WAIT) && (cnt_q == CNT_W'(TREE_LATENCY));
    assign handshake_s = m_valid_q && m_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: fill a frame, wait for the tree, hold until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (last_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = COLLECT;
                end
            end
            WAIT: begin
                if (cnt_done_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    state_d = COLLECT;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // FSM outputs: stream ready and the strobes for the sum checker.
    always_comb begin
        s_ready_s = 1'b0;
        add_en_s  = 1'b0;
        check_s   = 1'b0;
        clear_s   = 1'b0;
        case (state_q)
            COLLECT: begin
                s_ready_s = 1'b1;
                add_en_s  = s_valid;
            end
            WAIT: begin
                check_s = cnt_done_s;
            end
            HOLD: begin
                clear_s = handshake_s;
            end
            default: begin
                s_ready_s = 1'b0;
            end
        endcase
    end

    // Datapath next-state: operand slots, index, latency counter, result.
    always_comb begin
        op_bus_d     = op_bus_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        frame_done_d = handshake_s;
        if (accept_s) begin
            op_bus_d[idx_q*ADDER_WIDTH +: ADDER_WIDTH] = s_data;
            if (last_s) begin
                idx_d = '0;
                cnt_d = '0;
            end else begin
                idx_d = idx_q + LEVELS'(1);
            end
        end else begin
            idx_d = idx_q;
        end
        if (state_q == WAIT) begin
            if (cnt_done_s) begin
                cnt_d     = '0;
                m_data_d  = tree_sum;
                m_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (handshake_s) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_bus_q     <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            op_bus_q     <= op_bus_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    adder_tree_sum_check #(
        .ADDER_WIDTH   (ADDER_WIDTH),
        .LEVELS        (LEVELS),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_sum_check (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_s),
        .add_en_i    (add_en_s),
        .add_data_i  (s_data),
        .check_i     (check_s),
        .tree_sum_i  (tree_sum),
        .acc_o       (acc_s),
        .mismatch_o  (mismatch),
        .err_count_o (err_count)
    );

    assign s_ready    = s_ready_s;
    assign op_bus     = op_bus_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Scoreboard bench for adder_tree_feeder with a two-stage pipelined tree model.
module tb_adder_tree_feeder;

    localparam int AW = 6;
    localparam int LV = 3;
    localparam int NO = 8;
    localparam int SW = AW + LV;
    localparam int EW = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             s_valid;
    logic             s_ready;
    logic [AW-1:0]    s_data;
    logic [NO*AW-1:0] op_bus;
    logic [SW-1:0]    tree_sum;
    logic             m_valid;
    logic             m_ready;
    logic [SW-1:0]    m_data;
    logic             mismatch;
    logic [EW-1:0]    err_count;
    logic             frame_done;

    int            checks = 0;
    int            errors = 0;
    logic [SW-1:0] exp_q[$];
    bit            inject = 1'b0;
    int            exp_err = 0;
    bit            exp_mm = 1'b0;

    logic [SW-1:0] st1, st2;

    always #5 clk = ~clk;

    adder_tree_feeder #(
        .ADDER_WIDTH   (AW),
        .LEVELS        (LV),
        .TREE_LATENCY  (2),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .op_bus     (op_bus),
        .tree_sum   (tree_sum),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .mismatch   (mismatch),
        .err_count  (err_count),
        .frame_done (frame_done)
    );

    function automatic logic [SW-1:0] bus_sum(input logic [NO*AW-1:0] b);
        logic [SW-1:0] s;
        s = '0;
        for (int k = 0; k < NO; k++) s = s + SW'(b[k*AW +: AW]);
        return s;
    endfunction

    // Tree model: input register then output register, optional +1 fault.
    always @(posedge clk) begin
        st1 <= bus_sum(op_bus);
        st2 <= st1 + (inject ? 9'd1 : 9'd0);
    end
    assign tree_sum = st2;

    task automatic send_word(input logic [AW-1:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input int step, input int gap);
        logic [AW-1:0] w[NO];
        logic [SW-1:0] s;
        s = '0;
        for (int k = 0; k < NO; k++) begin
            w[k] = AW'(base + k * step);
            s    = s + SW'(w[k]);
            send_word(w[k]);
            if (gap > 0 && k < NO - 1) begin
                s_data = 6'h3F;
                repeat (gap) @(negedge clk);
            end
        end
        exp_q.push_back(s + (inject ? 9'd1 : 9'd0));
        if (inject) begin
            exp_mm  = 1'b1;
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        for (int k = 0; k < NO; k++) begin
            checks++;
            if (op_bus[k*AW +: AW] !== w[k]) begin
                errors++;
                $display("FAIL op_bus slot %0d: got %0d, required %0d", k, op_bus[k*AW +: AW], w[k]);
            end
        end
    endtask

    task automatic get_result(input int hold_cycles, output int lat);
        logic [SW-1:0] e;
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL result timeout: m_valid=%0b after %0d cycles, required 1", m_valid, n);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: result with empty queue, got m_data=%0d", m_data);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (m_data !== e) begin
            errors++;
            $display("FAIL m_data: got %0d, required %0d", m_data, e);
        end
        for (int i = 0; i < hold_cycles; i++) begin
            s_valid = 1'b1;
            s_data  = 6'h2A;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== e || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: m_valid=%0b m_data=%0d s_ready=%0b, required 1 %0d 0",
                         i, m_valid, m_data, s_ready, e);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake: frame_done=%0b m_valid=%0b, required 1 0", frame_done, m_valid);
        end
        checks++;
        if (mismatch !== exp_mm || err_count !== EW'(exp_err)) begin
            errors++;
            $display("FAIL error state: mismatch=%0b err_count=%0d, required %0b %0d",
                     mismatch, err_count, exp_mm, exp_err);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done pulse: got %0b one cycle later, required 0", frame_done);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (op_bus !== '0 || m_data !== '0 || m_valid !== 1'b0 || mismatch !== 1'b0 ||
            err_count !== '0 || frame_done !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset state: op_bus=%0h m_data=%0d m_valid=%0b mismatch=%0b err=%0d fd=%0b s_ready=%0b, required zeros and s_ready=1",
                     op_bus, m_data, m_valid, mismatch, err_count, frame_done, s_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        m_ready = 1'b1;
        send_frame(1, 1, 0);
        get_result(0, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 3", lat);
        end
    endtask

    task automatic test_max_operands();
        int lat;
        send_frame(63, 0, 0);
        get_result(0, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        m_ready = 1'b0;
        send_frame(5, 7, 0);
        get_result(5, lat);
        send_frame(20, 3, 0);
        get_result(0, lat);
    endtask

    task automatic test_mismatch();
        int lat;
        send_frame(2, 2, 0);
        get_result(0, lat);
        inject = 1'b1;
        send_frame(9, 1, 0);
        get_result(0, lat);
        inject = 1'b0;
        send_frame(30, 1, 0);
        get_result(0, lat);
    endtask

    task automatic test_async_reset();
        int lat;
        for (int k = 0; k < 4; k++) send_word(AW'(40 + k));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (op_bus !== '0 || m_data !== '0 || m_valid !== 1'b0 || mismatch !== 1'b0 ||
            err_count !== '0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async reset: op_bus=%0h m_data=%0d m_valid=%0b mismatch=%0b err=%0d fd=%0b, required zeros",
                     op_bus, m_data, m_valid, mismatch, err_count, frame_done);
        end
        exp_q.delete();
        exp_err = 0;
        exp_mm  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(10, 0, 0);
        get_result(0, lat);
    endtask

    task automatic test_gaps_and_saturation();
        int lat;
        send_frame(11, 5, 2);
        get_result(0, lat);
        inject = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_frame(i % 64, 1, 0);
            get_result(0, lat);
        end
        inject = 1'b0;
        checks++;
        if (err_count !== 8'hFF || mismatch !== 1'b1) begin
            errors++;
            $display("FAIL saturation: err_count=%0d mismatch=%0b, required 255 1", err_count, mismatch);
        end
    endtask

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        test_reset();
        test_basic();
        test_max_operands();
        test_backpressure();
        test_mismatch();
        test_async_reset();
        test_gaps_and_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
